// File: rtl/daq_pkg.sv
// Shared types and constants for the ADC trigger/frame write path.
// Frame word layout: {sof, eof, payload[13:0]}.
package daq_pkg;
   typedef enum logic [1:0] {IDLE, HDR, CAP, HOLD} state_e;

   localparam int SOF_BIT   = 15;
   localparam int EOF_BIT   = 14;
   localparam int HDR_WORDS = 3;
   localparam int TS_W      = 28;
   localparam int PAY_W     = 14;
   localparam int CNT_W     = 16;

   typedef struct packed {
      logic             sof;
      logic             eof;
      logic [PAY_W-1:0] payload;
   } fifo_word_t;
endpackage

// File: rtl/trig_edge_qual.sv
// Rising-edge detect on the trigger level and accept/drop qualification.
// Only an IDLE writer can accept or drop; everything else is ignored.
module trig_edge_qual (
   input  logic clk_adc,
   input  logic RESET,
   input  logic trig_i,
   input  logic run_en_i,
   input  logic afull_i,
   input  logic idle_i,
   output logic accept_o,
   output logic drop_o
);
   logic trig_prev_q;
   logic rise;

   always_ff @(posedge clk_adc or negedge RESET) begin
      if (!RESET) trig_prev_q <= 1'b0;
      else        trig_prev_q <= trig_i;
   end

   assign rise     = trig_i & ~trig_prev_q;
   assign accept_o = idle_i & rise & run_en_i & ~afull_i;
   assign drop_o   = idle_i & rise & run_en_i &  afull_i;
endmodule

// File: rtl/trig_frame_writer.sv
// Triggered frame writer: 3 header words then WIN_LEN samples into the data FIFO,
// followed by a hold-off; counts accepted and dropped triggers, flags overflow.
module trig_frame_writer
   import daq_pkg::*;
#(
   parameter int WIN_LEN = 64,
   parameter int HOLDOFF = 16
) (
   input  logic        clk_adc,
   input  logic        RESET,
   input  logic        run_en,
   input  logic        trig_in,
   input  logic        clr_cnt,
   input  logic [13:0] din,
   input  logic        fifo_full,
   input  logic        fifo_afull,
   output logic [15:0] fifo_wdata,
   output logic        fifo_wrreq,
   output logic        busy,
   output logic [13:0] evt_cnt,
   output logic [15:0] drop_cnt,
   output logic        overflow
);
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [TS_W-1:0]  ts_q, ts_d, ts_lat_q;
   logic             wrreq_q;
   fifo_word_t       wdata_q;
   logic [13:0]      evt_cnt_q;
   logic [15:0]      drop_cnt_q;
   logic             ovf_q;
   logic             accept, drop;

   trig_edge_qual u_qual (
      .clk_adc  (clk_adc),
      .RESET    (RESET),
      .trig_i   (trig_in),
      .run_en_i (run_en),
      .afull_i  (fifo_afull),
      .idle_i   (state_q == IDLE),
      .accept_o (accept),
      .drop_o   (drop)
   );

   assign ts_d = ts_q + TS_W'(1);

   always_ff @(posedge clk_adc or negedge RESET) begin
      if (!RESET) ts_q <= '0;
      else        ts_q <= ts_d;
   end

   // Outputs are registered one cycle ahead of the state they belong to, so
   // each state computes the word that appears on the bus next cycle.
   always_ff @(posedge clk_adc or negedge RESET) begin
      if (!RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ts_lat_q <= '0;
         wrreq_q  <= 1'b0;
         wdata_q  <= '0;
      end else begin
         wrreq_q <= 1'b0;
         wdata_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  // The header register itself holds the latched event number.
                  state_q  <= HDR;
                  cnt_q    <= '0;
                  ts_lat_q <= ts_q;
                  wrreq_q  <= 1'b1;
                  wdata_q  <= '{sof: 1'b1, eof: 1'b0, payload: evt_cnt_q};
               end
            end
            HDR: begin
               wrreq_q <= 1'b1;
               if (cnt_q == CNT_W'(HDR_WORDS - 1)) begin
                  state_q <= CAP;
                  cnt_q   <= '0;
                  wdata_q <= '{sof: 1'b0, eof: 1'b0, payload: din};
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == '0) wdata_q.payload <= ts_lat_q[TS_W-1 -: PAY_W];
                  else             wdata_q.payload <= ts_lat_q[PAY_W-1:0];
               end
            end
            CAP: begin
               if (cnt_q == CNT_W'(WIN_LEN - 1)) begin
                  state_q <= (HOLDOFF > 0) ? HOLD : IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
                  wrreq_q <= 1'b1;
                  wdata_q <= '{sof: 1'b0, eof: (cnt_q == CNT_W'(WIN_LEN - 2)), payload: din};
               end
            end
            HOLD: begin
               if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Clear wins over a same-cycle accept, drop or overflow.
   always_ff @(posedge clk_adc or negedge RESET) begin
      if (!RESET) begin
         evt_cnt_q  <= '0;
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else if (clr_cnt) begin
         evt_cnt_q  <= '0;
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         if (accept) evt_cnt_q <= evt_cnt_q + 14'd1;
         if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
         if (wrreq_q && fifo_full) ovf_q <= 1'b1;
      end
   end

   assign fifo_wdata = wdata_q;
   assign fifo_wrreq = wrreq_q;
   assign busy       = (state_q != IDLE);
   assign evt_cnt    = evt_cnt_q;
   assign drop_cnt   = drop_cnt_q;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_trig_frame_writer.sv
// Directed bench for trig_frame_writer: table of trigger qualifications plus
// hand sequences for hold-off, saturation, wrap, overflow and mid-frame reset.
module tb_trig_frame_writer;
   localparam int WL = 64;
   localparam int HO = 16;

   logic        clk_adc = 1'b0;
   logic        RESET = 1'b0;
   logic        run_en = 1'b0, trig_in = 1'b0, clr_cnt = 1'b0;
   logic        fifo_full = 1'b0, fifo_afull = 1'b0;
   logic [13:0] din;
   logic [15:0] fifo_wdata;
   logic        fifo_wrreq, busy, overflow;
   logic [13:0] evt_cnt;
   logic [15:0] drop_cnt;

   logic [27:0] tsm;
   logic [27:0] last_busy = '0;
   logic [15:0] wq[$];
   logic [27:0] cq[$];
   int          zero_bad = 0;
   int          passed = 0, total = 0;

   typedef struct {
      logic        run;
      logic        afull;
      int          words;
      logic [13:0] evt;
      logic [15:0] drop;
   } vec_t;
   vec_t vt[5];

   trig_frame_writer #(.WIN_LEN(WL), .HOLDOFF(HO)) dut (
      .clk_adc(clk_adc), .RESET(RESET), .run_en(run_en), .trig_in(trig_in),
      .clr_cnt(clr_cnt), .din(din), .fifo_full(fifo_full), .fifo_afull(fifo_afull),
      .fifo_wdata(fifo_wdata), .fifo_wrreq(fifo_wrreq), .busy(busy),
      .evt_cnt(evt_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
   );

   always #5 clk_adc = ~clk_adc;

   // Cycle index since reset release; din is a ramp on it.
   always @(posedge clk_adc or negedge RESET)
      if (!RESET) tsm <= '0;
      else        tsm <= tsm + 28'd1;

   assign din = 14'(tsm) + 14'h0100;

   always @(negedge clk_adc) begin
      if (fifo_wrreq) begin
         wq.push_back(fifo_wdata);
         cq.push_back(tsm);
      end else if (fifo_wdata != 16'h0) zero_bad++;
      if (busy) last_busy = tsm;
   end

   function automatic logic [13:0] dexp(input logic [27:0] c);
      return 14'(c) + 14'h0100;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic pulse_trig(output logic [27:0] t);
      @(posedge clk_adc); #1;
      trig_in = 1'b1;
      t = tsm;
      @(posedge clk_adc); #1;
      trig_in = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clk_adc);
         n++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'd0);
      repeat (2) @(negedge clk_adc);
   endtask

   task automatic check_frame(input logic [27:0] t, input logic [13:0] evt);
      int bad_c = 0, bad_s = 0;
      chk("nwords", wq.size(), WL + 3);
      if (wq.size() == WL + 3) begin
         chk("hdr_sof_evt", wq[0], {16'h8000 | {2'b00, evt}});
         chk("hdr_ts_hi", wq[1], {2'b00, t[27:14]});
         chk("hdr_ts_lo", wq[2], {2'b00, t[13:0]});
         chk("hdr_latency", cq[0], t + 28'd1);
         for (int k = 0; k < WL + 3; k++)
            if (cq[k] != t + 28'd1 + 28'(k)) bad_c++;
         for (int k = 0; k < WL; k++)
            if (wq[3+k] != {1'b0, (k == WL - 1), dexp(t + 28'd3 + 28'(k))}) bad_s++;
         chk("contiguous", bad_c, 0);
         chk("sample_ramp_eof", bad_s, 0);
         chk("busy_fall", last_busy, t + 28'd3 + 28'(WL) + 28'(HO));
      end
   endtask

   initial begin
      logic [27:0] t, tx;
      vt[0] = '{1'b1, 1'b0, WL + 3, 14'd4, 16'd0};
      vt[1] = '{1'b0, 1'b0, 0,      14'd4, 16'd0};
      vt[2] = '{1'b1, 1'b1, 0,      14'd4, 16'd1};
      vt[3] = '{1'b0, 1'b1, 0,      14'd4, 16'd1};
      vt[4] = '{1'b1, 1'b0, WL + 3, 14'd5, 16'd1};

      #3;
      chk("rst_wrreq", {31'b0, fifo_wrreq}, 0);
      chk("rst_wdata", fifo_wdata, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_evt", evt_cnt, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_ovf", {31'b0, overflow}, 0);
      #19 RESET = 1'b1;
      run_en = 1'b1;
      repeat (3) @(posedge clk_adc);

      // Single frame
      wq.delete(); cq.delete();
      pulse_trig(t);
      wait_idle();
      check_frame(t, 14'd0);
      chk("evt_after_1", evt_cnt, 1);

      // Edge during hold-off is ignored, next edge after IDLE is accepted
      wq.delete(); cq.delete();
      pulse_trig(t);
      repeat (76) @(posedge clk_adc);
      #1;
      chk("busy_in_hold", {31'b0, busy}, 1);
      pulse_trig(tx);
      wait_idle();
      chk("hold_edge_nwords", wq.size(), WL + 3);
      chk("hold_edge_drop", drop_cnt, 0);
      chk("hold_edge_evt", evt_cnt, 2);
      wq.delete(); cq.delete();
      pulse_trig(t);
      wait_idle();
      check_frame(t, 14'd2);
      chk("evt_after_3", evt_cnt, 3);

      // Qualification table
      for (int i = 0; i < 5; i++) begin
         run_en = vt[i].run;
         fifo_afull = vt[i].afull;
         wq.delete(); cq.delete();
         pulse_trig(t);
         wait_idle();
         chk($sformatf("tab%0d_words", i), wq.size(), vt[i].words);
         chk($sformatf("tab%0d_evt", i), evt_cnt, vt[i].evt);
         chk($sformatf("tab%0d_drop", i), drop_cnt, vt[i].drop);
      end
      run_en = 1'b1;
      fifo_afull = 1'b0;

      // Drop counter saturation
      #1 force dut.drop_cnt_q = 16'hFFFE;
      #1 release dut.drop_cnt_q;
      fifo_afull = 1'b1;
      wq.delete(); cq.delete();
      pulse_trig(t);
      wait_idle();
      chk("drop_to_ffff", drop_cnt, 16'hFFFF);
      pulse_trig(t);
      wait_idle();
      chk("drop_saturated", drop_cnt, 16'hFFFF);
      chk("drop_no_words", wq.size(), 0);
      fifo_afull = 1'b0;

      // Event counter wrap
      #1 force dut.evt_cnt_q = 14'h3FFF;
      #1 release dut.evt_cnt_q;
      wq.delete(); cq.delete();
      pulse_trig(t);
      wait_idle();
      check_frame(t, 14'h3FFF);
      chk("evt_wrapped", evt_cnt, 0);

      // fifo_full during CAP
      chk("ovf_clear_before", {31'b0, overflow}, 0);
      wq.delete(); cq.delete();
      pulse_trig(t);
      repeat (20) @(posedge clk_adc);
      #1 fifo_full = 1'b1;
      repeat (5) @(posedge clk_adc);
      #1 fifo_full = 1'b0;
      wait_idle();
      chk("ovf_nwords", wq.size(), WL + 3);
      chk("ovf_set", {31'b0, overflow}, 1);
      repeat (5) @(posedge clk_adc);
      #1;
      chk("ovf_sticky", {31'b0, overflow}, 1);
      clr_cnt = 1'b1;
      @(posedge clk_adc); #1;
      clr_cnt = 1'b0;
      chk("clr_ovf", {31'b0, overflow}, 0);
      chk("clr_evt", evt_cnt, 0);
      chk("clr_drop", drop_cnt, 0);

      // Reset mid-CAP
      pulse_trig(t);
      repeat (30) @(posedge clk_adc);
      @(negedge clk_adc);
      chk("pre_rst_wrreq", {31'b0, fifo_wrreq}, 1);
      RESET = 1'b0;
      trig_in = 1'b1;
      run_en = 1'b0;
      #1;
      chk("mid_rst_wrreq", {31'b0, fifo_wrreq}, 0);
      chk("mid_rst_wdata", fifo_wdata, 0);
      chk("mid_rst_busy", {31'b0, busy}, 0);
      chk("mid_rst_evt", evt_cnt, 0);
      repeat (3) @(negedge clk_adc);
      RESET = 1'b1;
      wq.delete(); cq.delete();
      repeat (3) @(posedge clk_adc);
      #1 run_en = 1'b1;
      repeat (20) @(posedge clk_adc);
      #1;
      chk("held_trig_words", wq.size(), 0);
      chk("held_trig_busy", {31'b0, busy}, 0);
      trig_in = 1'b0;
      pulse_trig(t);
      wait_idle();
      check_frame(t, 14'd0);
      chk("evt_after_rst", evt_cnt, 1);

      chk("wdata_zero_when_idle", zero_bad, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/trig_frame_writer.md
Name: trig_frame_writer

Overview:
Write-side controller between the ADC sample pipeline (80-deep delay line, clk_adc domain) and the dual-clock data FIFO.
- Replaces the free-running "write every cycle" path.
- On a qualified trigger edge, writes one tagged frame into the FIFO: 3 header words, then WIN_LEN delayed samples.
- Enforces a hold-off after each frame and reports dropped and overflowed events.

Parameters:
WIN_LEN, 64, samples per frame (2..4095)
HOLDOFF, 16, idle cycles forced after the EOF write (0 allowed)

Ports:
clk_adc  in  1  ADC-recovered sample clock
RESET  in  1  asynchronous, active-low reset
run_en  in  1  run enable, already synchronised to clk_adc
trig_in  in  1  OR of internal/external triggers, level, clk_adc domain
clr_cnt  in  1  synchronous clear of evt_cnt, drop_cnt, overflow
din  in  14  pipeline-delayed ADC sample
fifo_full  in  1  FIFO wrfull
fifo_afull  in  1  FIFO almost-full; deasserted guarantees ≥ WIN_LEN+3 free words
fifo_wdata  out  16  {sof, eof, payload[13:0]}
fifo_wrreq  out  1  FIFO write strobe
busy  out  1  high in any state other than IDLE
evt_cnt  out  14  accepted-frame counter
drop_cnt  out  16  dropped-trigger counter
overflow  out  1  sticky: a write was attempted while fifo_full

Behaviour:
- Reset: RESET=0 forces IDLE asynchronously. All outputs, the timestamp counter and trig_prev go to 0.
- Reset mid-frame: the frame is abandoned with no EOF; the downstream reader resyncs on SOF.
- ts: free-running 28-bit counter, +1 per cycle, wraps.
- Edge detect: trig_prev <= trig_in. Edge = trig_in & ~trig_prev.
- Acceptance at cycle T requires: state IDLE, edge, run_en=1, fifo_afull=0.
  - On acceptance, latch ts_lat <= ts and evt_lat <= evt_cnt.
  - evt_cnt increments at T+1, wraps modulo 2^14.
- Drop: in IDLE, edge with run_en=1 and fifo_afull=1. drop_cnt += 1, saturating at 0xFFFF. No frame is written.
- Edges while busy, or with run_en=0, are ignored and not counted.
- States:
  - IDLE: on acceptance -> HDR.
  - HDR: 3 cycles with wrreq=1, then -> CAP.
  - CAP: WIN_LEN cycles with wrreq=1, then -> HOLD if HOLDOFF>0, else IDLE.
  - HOLD: HOLDOFF cycles with wrreq=0, then -> IDLE.
- Header words (registered outputs):
  - T+1: {1,0,evt_lat}
  - T+2: {0,0,ts_lat[27:14]}
  - T+3: {0,0,ts_lat[13:0]}
- Samples:
  - Cycles T+4 .. T+3+WIN_LEN write {0,eof,din delayed 1 cycle}.
  - The first sample is din as seen at cycle T+3.
  - eof=1 only on the last sample.
  - Pre-trigger depth is set solely by the upstream delay line.
- Frame length is exactly WIN_LEN+3 words, contiguous; fifo_wrreq never deasserts mid-frame.
- run_en falling mid-frame: the frame completes normally.
- fifo_full=1 during any wrreq cycle:
  - wrreq is still driven and the FIFO discards the word.
  - overflow is set (sticky) and frame timing is unchanged.
- A new edge on the same cycle HOLD finishes is ignored; acceptance is only ever evaluated in IDLE.
- clr_cnt: clears the counters on the next edge.
  - If a drop or accept occurs in the same cycle, clr_cnt takes priority.
  - The already latched evt_lat is unaffected.
- fifo_wdata is held at 0 whenever wrreq=0.

Decomposition:
- Shared package (daq_pkg):
  - state encoding: IDLE, HDR, CAP, HOLD
  - tag bit positions: SOF_BIT=15, EOF_BIT=14
  - HDR_WORDS=3, TS_W=28
- One sub-module, trig_edge_qual: edge detector plus accept/drop qualification, returns accept and drop pulses.
- Counters and the FSM stay in the top of the block.

Test Plan:
- Single trigger, WIN_LEN=64, HOLDOFF=16, din ramp:
  - exactly 67 writes;
  - word0 = 0x8000 | evt;
  - words 1–2 = ts at acceptance;
  - samples form a contiguous ramp;
  - last word has bit14=1;
  - busy falls 16 cycles after EOF.
- Second edge 10 cycles into HOLD, then a third edge after IDLE:
  - the second edge produces no frame and drop_cnt is unchanged;
  - the third edge produces a frame with evt_cnt+1.
- fifo_afull=1 at the edge: no wrreq, drop_cnt 0->1. 0xFFFF further drops leave drop_cnt saturated at 0xFFFF.
- fifo_full pulsed for 5 cycles during CAP: overflow=1 sticky, still 67 wrreq cycles. clr_cnt then clears overflow and the counters.
- Event counter wrap: evt_cnt preloaded to 0x3FFF via 16383 triggers; the next frame header payload is 0x3FFF and evt_cnt reads 0x0000.
- RESET asserted mid-CAP:
  - wrreq and all outputs go to 0 immediately;
  - after release, trig_in held high produces no frame;
  - a fresh rising edge produces a frame with evt=0.
